steer_en_ctrl: RTL and testbench
================================

# steer_en_ctrl

Rider-detect and steering-enable sequencer that drives the control inputs of the balance controller. It samples the left and right load cells on each valid pulse and produces the signed load-cell difference. A three-state machine with a settle timer decides when a rider is present and balanced, and asserts `rider_off` and `en_steer` to the balance controller accordingly. It sits between the load-cell A2D interface and the balance controller, in the same clock domain.

## Interface
Parameters:
- `MIN_RIDER_WT`, default 12'h200: total load that must be exceeded to declare a rider present.
- `WT_HYST`, default 12'h040: hysteresis; rider is lost when total load < `MIN_RIDER_WT - WT_HYST`.
- `TMR_BITS`, default 26: settle-timer width; 2^26 cycles ≈ 1.34 s at 50 MHz.
- `FAST_SIM`, default 0: when 1, the timer terminal count uses only the low 15 bits.

Ports:
- `clk`  in  1  system clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `vld`  in  1  one-cycle strobe; new `lft_ld`/`rght_ld` sample present.
- `lft_ld`  in  12  left load cell, unsigned.
- `rght_ld`  in  12  right load cell, unsigned.
- `ld_cell_diff`  out  12  signed, saturated `lft_ld - rght_ld`, registered.
- `rider_off`  out  1  high when no rider is detected.
- `en_steer`  out  1  high when steering is enabled.

## Operation
- On a clock edge with `vld`=1:
  - `sum` (13-bit unsigned) is registered as `lft_ld + rght_ld`.
  - `diff` (13-bit signed) is registered as zero-extended `lft_ld` minus zero-extended `rght_ld`.
  - `ld_cell_diff` is registered as `diff` clamped to [-2048, 2047] (0x800..0x7FF).
- With `vld`=0, all three registers hold their values.
- Conditions, combinational on the registered values:
  - `abs_diff` = |diff|, 13-bit.
  - `sum_gt_min` = `sum > MIN_RIDER_WT`.
  - `sum_lt_min` = `sum < MIN_RIDER_WT - WT_HYST`.
  - `diff_gt_1_4` = `abs_diff > (sum >> 2)`.
  - `diff_gt_15_16` = `abs_diff > sum - (sum >> 4)`.
- Timer `tmr` is `TMR_BITS` wide. `tmr_full` means all ones across `TMR_BITS`, or across bits [14:0] only when `FAST_SIM`=1.
- State machine:
  - OFF:
    - if `sum_gt_min`: go to WAIT and clear `tmr`.
    - else stay.
  - WAIT:
    - if `sum_lt_min`: go to OFF.
    - else if `diff_gt_1_4`: clear `tmr` and stay.
    - else if `tmr_full`: go to STEER.
    - else increment `tmr`.
  - STEER:
    - if `sum_lt_min`: go to OFF.
    - else if `diff_gt_15_16`: go to WAIT and clear `tmr`.
    - else stay.
- Outputs are decoded from the state register only, so they are glitch-free:
  - `rider_off` = (state==OFF).
  - `en_steer` = (state==STEER).
- Loads between the two thresholds (`MIN_RIDER_WT - WT_HYST` ≤ sum ≤ `MIN_RIDER_WT`):
  - OFF stays OFF.
  - WAIT and STEER do not drop to OFF.
- Priority is rider loss first, then imbalance, then timer.

## Timing
- Reset (`rst`=1 at an edge, highest priority including mid-WAIT or STEER) gives:
  - state = OFF, `tmr` = 0, `sum` = 0, `diff` = 0.
  - `ld_cell_diff` = 0, `rider_off` = 1, `en_steer` = 0.
- `vld` sampled at edge k:
  - `sum`, `diff` and `ld_cell_diff` update after edge k.
  - State and outputs respond after edge k+1, i.e. 2-cycle latency.
- WAIT dwell:
  - `tmr` enters at 0 and increments once per cycle.
  - STEER is entered at the edge after `tmr` reaches terminal count.
  - Minimum dwell is therefore exactly 2^`TMR_BITS` cycles, or 2^15 cycles with `FAST_SIM`=1.
- Any `diff_gt_1_4` cycle in WAIT restarts the full dwell.
- The timer never wraps: `tmr_full` always exits WAIT or is pre-empted by a clear.
- `vld` asserted on consecutive cycles is legal; each sample replaces the previous one.

## Test plan
- **Reset:** assert `rst` for 2 cycles from any state → `rider_off`=1, `en_steer`=0, `ld_cell_diff`=0x000. A second `rst` pulse mid-WAIT returns to OFF and restarts the dwell from 0.
- **Balanced mount** (`FAST_SIM`=1): `lft_ld`=`rght_ld`=0x180 with `vld` every cycle →
  - `rider_off` falls 2 cycles after the first `vld`.
  - `en_steer` rises exactly 32768 cycles after that.
  - `ld_cell_diff`=0x000 throughout.
- **Imbalance in WAIT:** `lft_ld`=0x200, `rght_ld`=0x100 (sum 0x300, |diff| 0x100 > 0xC0) →
  - `en_steer` never rises and `tmr` holds 0.
  - After switching to 0x180/0x180, `en_steer` rises a full 32768 cycles later.
- **Steer exit:** in STEER, apply `lft_ld`=0x300, `rght_ld`=0x010 (|diff| 0x2F0 > 0x2DF) →
  - `en_steer` falls 2 cycles after `vld`.
  - `rider_off` stays 0.
  - `ld_cell_diff`=0x2F0.
- **Hysteresis:**
  - From STEER, sum 0x1D0 → stays STEER; sum 0x1B0 → OFF with `rider_off`=1.
  - From OFF, sum 0x1F0 → stays OFF; sum 0x201 → WAIT.
- **Saturation:**
  - `lft_ld`=0xFFF, `rght_ld`=0x000 → `ld_cell_diff`=0x7FF.
  - Swapped → 0x800.
  - `vld`=0 with new load values → `ld_cell_diff` unchanged.

Source files
------------

// File: rtl/steer_en_ctrl.sv
// steer_en_ctrl: rider detect and steering-enable sequencer for the balance controller
module steer_en_ctrl #(
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [11:0] WT_HYST = 12'h040,
  parameter int TMR_BITS = 26,
  parameter bit FAST_SIM = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic [11:0] ld_cell_diff,
  output logic        rider_off,
  output logic        en_steer
);
  typedef enum logic [1:0] {OFF, WAIT, STEER} state_t;
  localparam logic [12:0] ON_WT = {1'b0, MIN_RIDER_WT};
  localparam logic [12:0] OFF_WT = {1'b0, MIN_RIDER_WT - WT_HYST};
  state_t state, nxt;
  logic [12:0] sum, abs_diff;
  logic signed [12:0] diff, diff_in;
  logic [11:0] sat_in;
  logic [TMR_BITS-1:0] tmr, tmr_nxt;
  logic sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, tmr_full;
  assign diff_in = $signed({1'b0, lft_ld}) - $signed({1'b0, rght_ld});
  assign sat_in = diff_in > 13'sd2047 ? 12'h7FF : diff_in < -13'sd2048 ? 12'h800 : diff_in[11:0];
  assign abs_diff = diff[12] ? 13'(-diff) : 13'(diff);
  assign sum_gt_min = sum > ON_WT;
  assign sum_lt_min = sum < OFF_WT;
  assign diff_gt_1_4 = abs_diff > (sum >> 2);
  assign diff_gt_15_16 = abs_diff > sum - (sum >> 4);
  assign tmr_full = FAST_SIM ? &tmr[14:0] : &tmr;
  // load-cell sample registers, updated only on a valid strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
      diff <= '0;
      ld_cell_diff <= '0;
    end else if (vld) begin
      sum <= {1'b0, lft_ld} + {1'b0, rght_ld};
      diff <= diff_in;
      ld_cell_diff <= sat_in;
    end
  end
  // state and settle-timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      tmr <= '0;
    end else begin
      state <= nxt;
      tmr <= tmr_nxt;
    end
  end
  // next state: rider loss beats imbalance, imbalance beats the timer
  always_comb begin
    nxt = state;
    tmr_nxt = tmr;
    case (state)
      OFF: if (sum_gt_min) begin
        nxt = WAIT;
        tmr_nxt = '0;
      end
      WAIT: if (sum_lt_min) nxt = OFF;
        else if (diff_gt_1_4) tmr_nxt = '0;
        else if (tmr_full) nxt = STEER;
        else tmr_nxt = tmr + 1'b1;
      STEER: if (sum_lt_min) nxt = OFF;
        else if (diff_gt_15_16) begin
          nxt = WAIT;
          tmr_nxt = '0;
        end
      default: nxt = OFF;
    endcase
  end
  // outputs decoded from the state register alone so they never glitch
  always_comb begin
    rider_off = state == OFF;
    en_steer = state == STEER;
  end
endmodule

// File: tb/tb_steer_en_ctrl.sv
// tb_steer_en_ctrl: scoreboard bench for the rider-detect / steering-enable sequencer
module tb_steer_en_ctrl;
  logic clk = 1'b0, rst = 1'b1, vld = 1'b0;
  logic [11:0] lft_ld = '0, rght_ld = '0, ld_cell_diff;
  logic rider_off, en_steer;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {string name; int due; int sig; int exp;} item_t;
  item_t q[$];

  steer_en_ctrl #(.FAST_SIM(1'b1)) dut (
    .clk(clk), .rst(rst), .vld(vld), .lft_ld(lft_ld), .rght_ld(rght_ld),
    .ld_cell_diff(ld_cell_diff), .rider_off(rider_off), .en_steer(en_steer)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int act(int s);
    return s == 0 ? int'(ld_cell_diff) : s == 1 ? int'(rider_off) : s == 2 ? int'(en_steer) : int'(dut.tmr);
  endfunction

  // monitor: pops every expectation that falls due at this sampling point
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due <= cyc) begin
        checks++;
        if (q[i].due < cyc || act(q[i].sig) != q[i].exp) begin
          errors++;
          $display("FAIL %s: got 0x%0h expected 0x%0h (due %0d, now %0d)", q[i].name, act(q[i].sig), q[i].exp, q[i].due, cyc);
        end
        q.delete(i);
      end
    end
  end

  task automatic drive(input logic r, input logic v, input logic [11:0] l, input logic [11:0] rr);
    @(negedge clk);
    rst = r; vld = v; lft_ld = l; rght_ld = rr;
  endtask

  task automatic expect_at(input string nm, input int s, input int e, input int lat);
    q.push_back('{nm, cyc + lat, s, e});
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    drive(1, 1, 12'h100, 12'h050);
    expect_at("rst_diff", 0, 0, 1);
    expect_at("rst_off", 1, 1, 1);
    expect_at("rst_steer", 2, 0, 1);
    expect_at("rst_tmr", 3, 0, 1);
    drive(1, 1, 12'h100, 12'h050);
    drive(0, 0, 12'h000, 12'h000);
    expect_at("idle_off", 1, 1, 2);
    // balanced mount and full dwell
    drive(0, 1, 12'h180, 12'h180);
    expect_at("mount_off_hold", 1, 1, 1);
    expect_at("mount_off_fall", 1, 0, 2);
    expect_at("mount_diff", 0, 0, 1);
    expect_at("mount_diff_mid", 0, 0, 1000);
    expect_at("mount_steer_early", 2, 0, 2 + 32767);
    expect_at("mount_steer_rise", 2, 1, 2 + 32768);
    hold(2 + 32768);
    // hysteresis band keeps STEER
    drive(0, 1, 12'h0E8, 12'h0E8);
    expect_at("hyst_steer_keep", 2, 1, 2);
    expect_at("hyst_off_keep", 1, 0, 2);
    expect_at("hyst_steer_keep2", 2, 1, 5);
    hold(5);
    // steer exit on heavy imbalance
    drive(0, 1, 12'h300, 12'h010);
    expect_at("exit_diff", 0, 12'h2F0, 1);
    expect_at("exit_steer_hold", 2, 1, 1);
    expect_at("exit_steer_fall", 2, 0, 2);
    expect_at("exit_off", 1, 0, 2);
    hold(3);
    // imbalance in WAIT pins the timer at zero
    drive(0, 1, 12'h200, 12'h100);
    expect_at("imb_diff", 0, 12'h100, 1);
    expect_at("imb_tmr", 3, 0, 3);
    expect_at("imb_tmr_late", 3, 0, 50);
    expect_at("imb_steer", 2, 0, 50);
    expect_at("imb_off", 1, 0, 50);
    hold(60);
    drive(0, 1, 12'h180, 12'h180);
    expect_at("rebal_tmr", 3, 100, 101);
    expect_at("rebal_steer_early", 2, 0, 32768);
    expect_at("rebal_steer_rise", 2, 1, 32769);
    hold(32769);
    // rider loss below the low threshold
    drive(0, 1, 12'h0D8, 12'h0D8);
    expect_at("loss_steer_hold", 2, 1, 1);
    expect_at("loss_steer", 2, 0, 2);
    expect_at("loss_off", 1, 1, 2);
    hold(3);
    // from OFF, the band does not mount; just above MIN does
    drive(0, 1, 12'h0F8, 12'h0F8);
    expect_at("band_off", 1, 1, 2);
    expect_at("band_off2", 1, 1, 4);
    hold(4);
    drive(0, 1, 12'h101, 12'h100);
    expect_at("mount2_diff", 0, 1, 1);
    expect_at("mount2_off", 1, 0, 2);
    expect_at("mount2_steer", 2, 0, 2);
    hold(23);
    // reset mid-WAIT, then the dwell restarts from zero
    drive(1, 1, 12'h101, 12'h100);
    expect_at("rst2_off", 1, 1, 1);
    expect_at("rst2_diff", 0, 0, 1);
    expect_at("rst2_tmr", 3, 0, 1);
    expect_at("rst2_steer", 2, 0, 1);
    drive(1, 1, 12'h101, 12'h100);
    drive(0, 0, 12'h101, 12'h100);
    expect_at("rst2_idle_off", 1, 1, 3);
    hold(3);
    drive(0, 1, 12'h180, 12'h180);
    expect_at("remount_off", 1, 0, 2);
    expect_at("remount_tmr0", 3, 0, 2);
    expect_at("remount_tmr10", 3, 10, 12);
    hold(13);
    // saturation and hold without vld
    drive(0, 1, 12'hFFF, 12'h000);
    expect_at("sat_pos", 0, 12'h7FF, 1);
    drive(0, 1, 12'h000, 12'hFFF);
    expect_at("sat_neg", 0, 12'h800, 1);
    drive(0, 0, 12'h123, 12'h456);
    expect_at("novld_hold", 0, 12'h800, 1);
    expect_at("novld_hold2", 0, 12'h800, 3);
    hold(4);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
